vga_timing_gen: RTL and testbench

Raster timing generator for the 1280x1024@60 Hz display path. It produces the `CounterX`/`CounterY` pixel coordinates, sync pulses and active-video flag that feed the background colour generator and later compositing stages directly. All outputs are registered and mutually aligned, so downstream combinational colour logic sees a consistent coordinate/sync set every cycle.

---
 rtl/vga_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen
//   Raster timing generator for the 1280x1024@60 Hz display path. Two cascaded
//   modulo counters (pixel column, line) plus a registered decode of sync,
//   active-video and start-of-line/frame pulses. The decode is computed from
//   the next counter values, so every output describes the coordinate shown
//   on CounterX/CounterY in the same clock.
//
//   Optional feature macro: VGA_FRAME_CNT_EN adds the frame_count port and
//   register (completed-frame counter, wraps silently at 16 bits).
//
// Ports
//   clk          in   pixel-domain clock
//   rst          in   asynchronous active-high reset
//   pix_en       in   pixel advance enable (tie high when clk is the pixel clock)
//   CounterX     out  [11:0] current column, 0..H_TOTAL-1
//   CounterY     out  [11:0] current line, 0..V_TOTAL-1
//   hsync        out  horizontal sync, asserted at HS_POL
//   vsync        out  vertical sync, asserted at VS_POL
//   video_on     out  high inside the visible area
//   line_start   out  one-clock pulse when CounterX becomes 0
//   frame_start  out  one-clock pulse when (CounterX,CounterY) becomes (0,0)
//   frame_count  out  [15:0] completed frames (VGA_FRAME_CNT_EN only)
module vga_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 48,
  parameter int   H_SYNC   = 112,
  parameter int   H_BP     = 248,
  parameter int   V_ACTIVE = 1024,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 38,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [11:0] CounterX,
  output logic [11:0] CounterY,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 4096");
  end

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Window bounds are 13 bits wide so an upper bound of exactly 4096 does
  // not alias to zero.
  localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
  localparam logic [12:0] HS_LO     = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_HI     = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_LO     = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_HI     = 13'(V_ACTIVE + V_FP + V_SYNC);

  // Half-open window test lo <= v < hi.
  function automatic logic in_window(input logic [11:0] v,
                                     input logic [12:0] lo,
                                     input logic [12:0] hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
  endfunction

  // Sync level for a given in-window flag and polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  logic [11:0] r_x_p0;
  logic [11:0] r_y_p0;
  logic        r_hs_p0;
  logic        r_vs_p0;
  logic        r_vid_p0;
  logic        r_ls_p0;
  logic        r_fs_p0;

  logic        w_x_wrap;
  logic        w_y_wrap;
  logic [11:0] w_x_nxt;
  logic [11:0] w_y_nxt;

  always_comb begin
    w_x_wrap = (r_x_p0 == H_LAST);
    w_y_wrap = (r_y_p0 == V_LAST);
    w_x_nxt  = r_x_p0 + 12'd1;
    w_y_nxt  = r_y_p0;
    if (w_x_wrap) begin
      w_x_nxt = '0;
      w_y_nxt = w_y_wrap ? '0 : r_y_p0 + 12'd1;
    end
  end

  // Stage p0: counters and decode of the next coordinate, all in one register
  // stage so coordinates and syncs never skew. Pulses drop while pix_en is low
  // so a held coordinate cannot produce a repeated pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x_p0   <= '0;
      r_y_p0   <= '0;
      r_hs_p0  <= ~HS_POL;
      r_vs_p0  <= ~VS_POL;
      r_vid_p0 <= 1'b1;
      r_ls_p0  <= 1'b0;
      r_fs_p0  <= 1'b0;
    end else if (pix_en) begin
      r_x_p0   <= w_x_nxt;
      r_y_p0   <= w_y_nxt;
      r_hs_p0  <= sync_level(in_window(w_x_nxt, HS_LO, HS_HI), HS_POL);
      r_vs_p0  <= sync_level(in_window(w_y_nxt, VS_LO, VS_HI), VS_POL);
      r_vid_p0 <= in_window(w_x_nxt, 13'd0, H_ACT_END) &&
                  in_window(w_y_nxt, 13'd0, V_ACT_END);
      r_ls_p0  <= w_x_wrap;
      r_fs_p0  <= w_x_wrap && w_y_wrap;
    end else begin
      r_ls_p0  <= 1'b0;
      r_fs_p0  <= 1'b0;
    end
  end

  assign CounterX    = r_x_p0;
  assign CounterY    = r_y_p0;
  assign hsync       = r_hs_p0;
  assign vsync       = r_vs_p0;
  assign video_on    = r_vid_p0;
  assign line_start  = r_ls_p0;
  assign frame_start = r_fs_p0;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_fc_p0;

  // Stage p0: increments in the same clock frame_start rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fc_p0 <= '0;
    end else if (pix_en && w_x_wrap && w_y_wrap) begin
      r_fc_p0 <= r_fc_p0 + 16'd1;
    end
  end

  assign frame_count = r_fc_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen. A default-parameter instance covers reset, line
// wrap, the hsync sweep and pix_en gating; a scaled-down instance
// (16 x 10 raster) covers frame wrap, vsync, frame_start spacing and a
// mid-frame reset within a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pix_en;
  logic [11:0] cx, cy;
  logic        hs, vs, vo, ls, fs;

  logic        rst_s, pix_en_s;
  logic [11:0] cx_s, cy_s;
  logic        hs_s, vs_s, vo_s, ls_s, fs_s;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc, fc_s;
`endif

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .CounterX(cx), .CounterY(cy), .hsync(hs), .vsync(vs),
    .video_on(vo), .line_start(ls), .frame_start(fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(fc)
`endif
  );

  // Small raster: H 8+2+3+3=16 (hsync X=10..12), V 6+1+2+1=10 (vsync Y=7..8).
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .pix_en(pix_en_s),
    .CounterX(cx_s), .CounterY(cy_s), .hsync(hs_s), .vsync(vs_s),
    .video_on(vo_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(fc_s)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks and settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model of the small raster.
  int ex, ey;
  bit e_ls, e_fs;
  task automatic model_step();
    bit xw, yw;
    xw   = (ex == 15);
    yw   = (ey == 9);
    e_ls = xw;
    e_fs = xw && yw;
    if (xw) begin
      ex = 0;
      ey = yw ? 0 : ey + 1;
    end else begin
      ex = ex + 1;
    end
  endtask

  int xerr, hs_n, hs_first, hs_last, vo_first, vo_err;
  int s_xy, s_hs, s_vs, s_vo, s_ls, s_fs, vs_n, fs1, fs2;
  int fc1, fc2;
  bit found;

  initial begin
    rst = 1'b1; pix_en = 1'b1;
    rst_s = 1'b1; pix_en_s = 1'b1;
    tick(3);

    // Reset held with pix_en high.
    chk("rst_x", cx, 0);
    chk("rst_y", cy, 0);
    chk("rst_video_on", vo, 1);
    chk("rst_hsync", hs, 0);
    chk("rst_vsync", vs, 0);
    chk("rst_line_start", ls, 0);
    chk("rst_frame_start", fs, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("rst_frame_count", fc, 0);
`endif

    rst = 1'b0;
    tick(5);
    chk("x_after_5", cx, 5);
    chk("y_after_5", cy, 0);

    // Sweep rest of line 0.
    xerr = 0; hs_n = 0; hs_first = -1; hs_last = -1; vo_first = -1; vo_err = 0;
    for (int k = 6; k <= 1687; k++) begin
      tick(1);
      if (cx !== 12'(k)) xerr++;
      if (hs === 1'b1) begin
        if (hs_first < 0) hs_first = k;
        hs_last = k;
        hs_n++;
      end
      if (vo === 1'b0 && vo_first < 0) vo_first = k;
      if (vo !== (k < 1280)) vo_err++;
    end
    chk("sweep_x_track", xerr, 0);
    chk("hsync_count", hs_n, 112);
    chk("hsync_first_x", hs_first, 1328);
    chk("hsync_last_x", hs_last, 1439);
    chk("video_off_first_x", vo_first, 1280);
    chk("video_on_pattern", vo_err, 0);
    chk("pre_wrap_x", cx, 1687);
    chk("pre_wrap_y", cy, 0);

    // Line wrap.
    tick(1);
    chk("wrap_x", cx, 0);
    chk("wrap_y", cy, 1);
    chk("wrap_line_start", ls, 1);
    chk("wrap_frame_start", fs, 0);
    tick(1);
    chk("post_wrap_line_start", ls, 0);
    chk("post_wrap_x", cx, 1);

    // Enable gating around X=1687.
    tick(1686);
    chk("gate_x_1687", cx, 1687);
    pix_en = 1'b0;
    tick(1);
    chk("gate_hold1_x", cx, 1687);
    chk("gate_hold1_y", cy, 1);
    chk("gate_hold1_ls", ls, 0);
    tick(1);
    chk("gate_hold2_x", cx, 1687);
    chk("gate_hold2_y", cy, 1);
    pix_en = 1'b1;
    tick(1);
    chk("gate_wrap_x", cx, 0);
    chk("gate_wrap_y", cy, 2);
    chk("gate_wrap_ls", ls, 1);
    pix_en = 1'b0;
    tick(1);
    chk("gate_held0_ls", ls, 0);
    chk("gate_held0_x", cx, 0);
    chk("gate_held0_y", cy, 2);
    pix_en = 1'b1;
    tick(1);
    chk("gate_resume_x", cx, 1);
    chk("gate_resume_ls", ls, 0);

    // Small raster: frame wrap, vsync, frame_start spacing.
    rst_s = 1'b0;
    ex = 0; ey = 0;
    s_xy = 0; s_hs = 0; s_vs = 0; s_vo = 0; s_ls = 0; s_fs = 0;
    vs_n = 0; fs1 = -1; fs2 = -1; fc1 = -1; fc2 = -1;
    for (int k = 1; k <= 330; k++) begin
      tick(1);
      model_step();
      if (cx_s !== 12'(ex) || cy_s !== 12'(ey)) s_xy++;
      if (hs_s !== (ex >= 10 && ex <= 12)) s_hs++;
      if (vs_s !== (ey >= 7 && ey <= 8)) s_vs++;
      if (vo_s !== (ex < 8 && ey < 6)) s_vo++;
      if (ls_s !== e_ls) s_ls++;
      if (fs_s !== e_fs) s_fs++;
      if (k <= 160 && vs_s === 1'b1) vs_n++;
      if (fs_s === 1'b1) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
`ifdef VGA_FRAME_CNT_EN
      if (k == 160) fc1 = int'(fc_s);
      if (k == 320) fc2 = int'(fc_s);
`endif
    end
    chk("s_coords", s_xy, 0);
    chk("s_hsync", s_hs, 0);
    chk("s_vsync", s_vs, 0);
    chk("s_video_on", s_vo, 0);
    chk("s_line_start", s_ls, 0);
    chk("s_frame_start", s_fs, 0);
    chk("s_vsync_cycles", vs_n, 32);
    chk("s_first_frame_start", fs1, 160);
    chk("s_frame_period", fs2 - fs1, 160);
`ifdef VGA_FRAME_CNT_EN
    chk("s_frame_count_1", fc1, 1);
    chk("s_frame_count_2", fc2, 2);
`endif

    // Seek to X=11, Y=8 (both syncs active), then reset between edges.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick(1);
      model_step();
      if (ex == 11 && ey == 8) found = 1'b1;
    end
    chk("s_seek_reached", found, 1);
    chk("s_pre_rst_x", cx_s, 11);
    chk("s_pre_rst_y", cy_s, 8);
    chk("s_pre_rst_hsync", hs_s, 1);
    chk("s_pre_rst_vsync", vs_s, 1);
    #2;
    rst_s = 1'b1;
    #1;
    chk("s_midrst_hsync", hs_s, 0);
    chk("s_midrst_vsync", vs_s, 0);
    chk("s_midrst_x", cx_s, 0);
    chk("s_midrst_y", cy_s, 0);
    chk("s_midrst_video_on", vo_s, 1);
`ifdef VGA_FRAME_CNT_EN
    chk("s_midrst_frame_count", fc_s, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
